seq_gen_serial_tx: RTL
======================

Name: seq_gen_serial_tx

Overview:
Serial pattern transmitter. It emits a programmable W-bit pattern MSB-first, one bit per clock, repeated a programmed number of times with optional zero-gap bits between repetitions. It is the stimulus/source end of the serial bit-stream interface consumed by the team's sequence-detector blocks. The default pattern is 4'b1011.

Parameters:
W, 4, pattern width in bits (2..16)
DEF_PATTERN, 4'b1011, value used when use_default=1 at start
CNT_W, 8, width of repeat count and frame counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request to begin a transmission, sampled on rising clk
use_default  input  1  at start: 1 selects DEF_PATTERN, 0 selects pattern
pattern  input  W  user pattern, latched on accepted start
repeat_cnt  input  CNT_W  number of pattern repetitions, latched on accepted start
gap  input  4  zero bits inserted between repetitions, latched on accepted start
out  output  1  serial data bit
out_valid  output  1  out carries a stream bit this cycle
busy  output  1  transmission in progress (start ignored)
done  output  1  one-cycle pulse at end of transmission
frames_sent  output  CNT_W  completed pattern repetitions in current/last transmission

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk and reset_n, with reset_n=0 forcing state immediately, regardless of clk.
- Reset values: state=IDLE, out=0, out_valid=0, busy=0, done=0, frames_sent=0, internal latches=0.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 accepted on edge k. Latch pattern (or DEF_PATTERN), repeat_cnt, gap.
  - Clear frames_sent. Assert busy from edge k.
  - If repeat_cnt!=0: go to SHIFT with bit index=W-1. The first bit (MSB) appears with out_valid=1 after edge k+1.
  - If repeat_cnt==0: go directly to DONE. No bits are emitted.
- SHIFT:
  - Each cycle: out=latched_pattern[idx], out_valid=1.
  - When idx=0: increment frames_sent and decrement remaining.
    - remaining becomes 0: go to DONE.
    - else gap==0: stay in SHIFT, idx=W-1. Back-to-back repetitions, no bubble.
    - else: go to GAP with gap counter=gap.
  - When idx>0: idx decrements.
- GAP: out=0, out_valid=1 for exactly gap cycles, then SHIFT with idx=W-1.
- DONE:
  - out_valid=0, out=0, done=1 for exactly one cycle, busy=0 in that cycle. Next state is IDLE.
  - start in the DONE cycle is ignored.
- start while busy=1 is ignored. Latched values do not change mid-transmission. Input changes to pattern/repeat_cnt/gap while busy have no effect.
- When out_valid=0, out is 0.
- frames_sent holds its final value after done until the next accepted start. It saturates at 2^CNT_W-1 (cannot overflow because it is ≤ repeat_cnt).
- Total valid cycles per transmission = W*repeat_cnt + gap*(repeat_cnt-1) for repeat_cnt≥1.
- Reset mid-transmission: outputs return to reset values immediately. No done pulse. A fresh start is required.

Test Plan:
- Reset, then start, use_default=1, repeat_cnt=1, gap=0 -> out_valid=1 for 4 cycles with out=1,0,1,1 starting one cycle after start. done pulses in the 5th cycle. frames_sent=1.
- use_default=1, repeat_cnt=3, gap=2 -> 16 valid cycles, stream 1011 00 1011 00 1011, then single done pulse. frames_sent steps 1,2,3.
- use_default=0, pattern=4'b0110, repeat_cnt=2, gap=0 -> 8 contiguous valid bits 01100110 with no bubble, done, frames_sent=2.
- repeat_cnt=0 with start -> no out_valid, done pulses one cycle after start. frames_sent=0. busy high only at the DONE edge pair.
- Hold start high and change pattern during a repeat_cnt=2 transmission -> stream unchanged, exactly one transmission until DONE. A new transmission begins only after return to IDLE.
- Assert reset_n=0 asynchronously during the 2nd bit -> out, out_valid, busy, done, frames_sent go to 0 without waiting for clk. No done pulse. Next start transmits correctly from MSB.

Source files
------------

// File: rtl/seq_gen_serial_tx_if.sv
// Handshake/control and serial-stream bundle for seq_gen_serial_tx.
// master = stimulus side, slave = transmitter side.
interface seq_gen_serial_tx_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             use_default;
    logic [W-1:0]     pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [3:0]       gap;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    modport master (
        output start, use_default, pattern, repeat_cnt, gap,
        input  out, out_valid, busy, done, frames_sent
    );

    modport slave (
        input  start, use_default, pattern, repeat_cnt, gap,
        output out, out_valid, busy, done, frames_sent
    );
endinterface

// File: rtl/seq_gen_serial_tx.sv
// Serial pattern transmitter: W-bit pattern MSB-first, repeated,
// with optional zero-gap bits between repetitions. All outputs registered.
module seq_gen_serial_tx #(
    parameter int             W           = 4,
    parameter logic [W-1:0]   DEF_PATTERN = 4'b1011,
    parameter int             CNT_W       = 8
) (
    input logic                clk,
    input logic                reset_n,
    seq_gen_serial_tx_if.slave bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [W-1:0]     r_pat;
    logic [CNT_W-1:0] r_rem;
    logic [3:0]       r_gap;
    logic [3:0]       r_gcnt;
    logic [IW-1:0]    r_idx;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_frames;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_pat    <= '0;
            r_rem    <= '0;
            r_gap    <= '0;
            r_gcnt   <= '0;
            r_idx    <= '0;
            r_out    <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_frames <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    // the cycle showing done is still part of the old transfer
                    if (bus.start && !r_done) begin
                        r_pat    <= bus.use_default ? DEF_PATTERN : bus.pattern;
                        r_rem    <= bus.repeat_cnt;
                        r_gap    <= bus.gap;
                        r_frames <= '0;
                        r_busy   <= 1'b1;
                        r_idx    <= IDX_MAX;
                        r_state  <= (bus.repeat_cnt != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    r_out   <= r_pat[r_idx];
                    r_valid <= 1'b1;
                    if (r_idx == '0) begin
                        if (r_frames != {CNT_W{1'b1}})
                            r_frames <= r_frames + 1'b1;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end else if (r_gap == '0) begin
                            r_idx <= IDX_MAX;
                        end else begin
                            r_gcnt  <= r_gap;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_GAP: begin
                    r_out   <= 1'b0;
                    r_valid <= 1'b1;
                    r_gcnt  <= r_gcnt - 1'b1;
                    if (r_gcnt == 4'd1) begin
                        r_idx   <= IDX_MAX;
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    r_out   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out         = r_out;
    assign bus.out_valid   = r_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.frames_sent = r_frames;

endmodule
